// File: rtl/fact_accel.sv
// rtl/fact_accel.sv - memory-mapped iterative factorial accelerator
//
// Purpose: computes N! with one multiply per clock. The core writes N, then
// writes GO. It then polls STATUS or waits for done_irq, and reads RESULT.
//
// Ports:
//   clk       system clock, rising edge active
//   rst       asynchronous active-high reset
//   we        write enable, already qualified by the address decoder
//   a         word offset: 0=N, 1=GO, 2=STATUS, 3=RESULT
//   wd        write data
//   rd        read data, combinational from a
//   done_irq  high while the DONE flag is set
//   busy      high while a computation is running
module fact_accel #(
  parameter int WIDTH = 32,
  parameter int NBITS = 4,
  parameter int NMAX  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       a,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             done_irq,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [NBITS-1:0] NMAX_L  = NBITS'(NMAX);
  localparam logic [NBITS-1:0] CNT_ONE = NBITS'(1);

  state_t           state_q, state_d;
  logic [NBITS-1:0] n_q, n_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             n_wr;
  logic             go_wr;
  logic [WIDTH-1:0] mul_w;
  logic             wd_unused;

  // Only the low bits of wd are meaningful to this block.
  assign wd_unused = ^wd[WIDTH-1:NBITS];

  // N and GO writes are dropped while a computation is running, so the
  // operand stays stable and a running job cannot be restarted.
  assign n_wr  = we && (a == 2'd0) && (state_q != S_CALC);
  assign go_wr = we && (a == 2'd1) && wd[0] && (state_q != S_CALC);

  // WIDTH x NBITS product. The upper bits are dropped; for N <= NMAX the
  // running product always fits in WIDTH bits.
  assign mul_w = prod_q * {{(WIDTH-NBITS){1'b0}}, cnt_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= WIDTH'(1);
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_CALC: begin
        // Counting down from N; the last factor (1) is never multiplied.
        // This also makes 0! and 1! finish after a single edge.
        if (cnt_q <= CNT_ONE) begin
          result_d = prod_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          prod_d = mul_w;
          cnt_d  = cnt_q - CNT_ONE;
        end
      end
      default: begin
        // IDLE and DONE behave the same: accept N, start on GO.
        if (n_wr) begin
          n_d = wd[NBITS-1:0];
        end
        if (go_wr) begin
          if (n_q > NMAX_L) begin
            // Out-of-range operand: report the error without computing.
            state_d  = S_DONE;
            result_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            prod_d  = WIDTH'(1);
            cnt_d   = n_q;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
    endcase
  end

  assign busy     = (state_q == S_CALC);
  assign done_irq = done_q;

  always_comb begin
    rd = '0;
    case (a)
      2'd0:    rd = {{(WIDTH-NBITS){1'b0}}, n_q};
      2'd1:    rd = {{(WIDTH-1){1'b0}}, busy};
      2'd2:    rd = {{(WIDTH-2){1'b0}}, err_q, done_q};
      default: rd = result_q;
    endcase
  end

endmodule

// File: tb/tb_fact_accel.sv
// tb/tb_fact_accel.sv - self-checking bench for fact_accel
module tb_fact_accel;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             we;
  logic [1:0]       a;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;
  logic             done_irq;
  logic             busy;

  int n_total = 0;
  int n_pass  = 0;

  fact_accel #(.WIDTH(WIDTH), .NBITS(4), .NMAX(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .a        (a),
    .wd       (wd),
    .rd       (rd),
    .done_irq (done_irq),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: tracks the operand, flags, result and how many
  // edges remain before the running job completes.
  int          m_n;
  logic [31:0] m_result;
  bit          m_done;
  bit          m_err;
  bit          m_busy;
  int          m_left;
  logic [31:0] m_pend;

  function automatic logic [31:0] fact(input int n);
    longint p;
    p = 1;
    for (int k = 2; k <= n; k++) p = p * k;
    return p[31:0];
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] addr);
    case (addr)
      2'd0:    return 32'(m_n);
      2'd1:    return {31'd0, m_busy};
      2'd2:    return {30'd0, m_err, m_done};
      default: return m_result;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_result = 0; m_done = 0; m_err = 0; m_busy = 0; m_left = 0; m_pend = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy   = 0;
        m_done   = 1;
        m_result = m_pend;
      end
    end else if (we) begin
      if (a == 2'd0) begin
        m_n = int'(wd[3:0]);
      end else if (a == 2'd1 && wd[0]) begin
        if (m_n > 12) begin
          m_done = 1; m_err = 1; m_result = 0;
        end else begin
          m_busy = 1;
          m_left = (m_n == 0) ? 1 : m_n;
          m_pend = fact(m_n);
          m_done = 0;
          m_err  = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done_irq", {31'd0, done_irq}, {31'd0, m_done});
      chk($sformatf("rd[a=%0d]", a), rd, model_rd(a));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    step();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(name, rd, exp);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; we = 1'b0; a = 2'd0; wd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Model anchors
    chk("model_fact5", fact(5), 32'd120);
    chk("model_fact12", fact(12), 32'h1C8CFC00);

    // Reset state
    rd_chk("rst_n", 2'd0, 32'd0);
    rd_chk("rst_go", 2'd1, 32'd0);
    rd_chk("rst_status", 2'd2, 32'd0);
    rd_chk("rst_result", 2'd3, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, done_irq}, 32'd0);

    // 5! : busy for five edges
    wr(2'd0, 32'd5); wr(2'd1, 32'd1);
    chk("n5_busy_e0", {31'd0, busy}, 32'd1);
    repeat (4) step();
    rd_chk("n5_status_e4", 2'd2, 32'd0);
    step();
    rd_chk("n5_status_e5", 2'd2, 32'd1);
    rd_chk("n5_result", 2'd3, 32'd120);
    chk("n5_irq", {31'd0, done_irq}, 32'd1);

    // 12! : largest legal operand
    wr(2'd0, 32'd12); wr(2'd1, 32'd1);
    repeat (11) step();
    chk("n12_busy_e11", {31'd0, busy}, 32'd1);
    step();
    rd_chk("n12_result", 2'd3, 32'h1C8CFC00);
    rd_chk("n12_status", 2'd2, 32'd1);

    // 13 is out of range, then 0! = 1
    wr(2'd0, 32'd13); wr(2'd1, 32'd1);
    chk("n13_busy", {31'd0, busy}, 32'd0);
    rd_chk("n13_status", 2'd2, 32'd3);
    rd_chk("n13_result", 2'd3, 32'd0);
    wr(2'd0, 32'd0); wr(2'd1, 32'd1);
    step();
    rd_chk("n0_status", 2'd2, 32'd1);
    rd_chk("n0_result", 2'd3, 32'd1);

    // Writes during CALC are ignored
    wr(2'd0, 32'd6); wr(2'd1, 32'd1);
    step();
    wr(2'd0, 32'd3); wr(2'd1, 32'd1);
    step(); step();
    chk("n6_busy_e5", {31'd0, busy}, 32'd1);
    step();
    rd_chk("n6_result", 2'd3, 32'd720);
    rd_chk("n6_n", 2'd0, 32'd6);

    // Asynchronous reset mid-computation
    wr(2'd0, 32'd10); wr(2'd1, 32'd1);
    repeat (4) step();
    #2 rst = 1'b1;
    #1 chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_irq", {31'd0, done_irq}, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("arst_rd%0d", i), 2'(i), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    step();
    wr(2'd0, 32'd4); wr(2'd1, 32'd1);
    repeat (4) step();
    rd_chk("n4_result", 2'd3, 32'd24);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1: wr(2'd0, r);
        2, 3: wr(2'd1, (r[3:0] != 4'd0) ? (r | 32'd1) : (r & ~32'd1));
        4:    wr(2'($urandom_range(2, 3)), r);
        default: begin
          repeat ($urandom_range(1, 6)) begin
            a = 2'($urandom_range(0, 3));
            step();
          end
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fact_accel.md
Name: fact_accel

Overview:
- Memory-mapped factorial accelerator that computes n! iteratively, one multiply per cycle.
- Sits directly downstream of the pipelined core's data-memory port (we_dmM, alu_out, wd_dm, rd_dm), selected by the system address decoder.
- The core starts a computation by writing N and then GO. It polls STATUS, or waits for done_irq, then reads RESULT.

Parameters:
- WIDTH, 32, data/result width in bits.
- NBITS, 4, width of the N operand register.
- NMAX, 12, largest n whose factorial fits in WIDTH bits; n > NMAX is an error.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  reset, asynchronous, active-high
- we  input  1  write enable (driven from we_dmM gated by the decoder select)
- a  input  2  word address within the block (byte address bits [3:2])
- wd  input  WIDTH  write data (wd_dm)
- rd  output  WIDTH  read data, combinational from a
- done_irq  output  1  high while the DONE flag is set
- busy  output  1  high while in CALC

Behaviour:
- Register map (word offset a):
  - 0: N, RW, holds wd[NBITS-1:0]; reads zero-extended.
  - 1: GO, write wd[0]=1 to start; reads {0, busy}.
  - 2: STATUS, RO, reads {0, err, done}.
  - 3: RESULT, RO.
- Writes to STATUS and RESULT are ignored.
- Read is combinational: rd = selected register, no read side effects.
- Reset (async, any state, including mid-CALC): state=IDLE, N=0, prod=1, cnt=0, result=0, done=0, err=0. Outputs: rd reflects reset values, busy=0, done_irq=0.
- FSM states: IDLE, CALC, DONE.
- Start condition, all on edge E0: we=1, a=1, wd[0]=1, state != CALC.
  - If N <= NMAX: state<=CALC, prod<=1, cnt<=N, done<=0, err<=0.
  - If N > NMAX: state<=DONE, result<=0, err<=1, done<=1, no computation.
- GO write with wd[0]=0: ignored.
- GO write while in CALC: ignored; the computation continues undisturbed.
- N write while in CALC: ignored; N is stable during a computation. N writes in IDLE or DONE are accepted and do not clear done/err.
- CALC, each edge:
  - If cnt <= 1: result<=prod, done<=1, state<=DONE.
  - Otherwise: prod <= (prod*cnt) truncated to WIDTH, cnt<=cnt-1.
- Latency: done rises after max(N,1) edges following E0.
  - N=0 and N=1 give result 1 after 1 edge.
- DONE: holds result, done and err until the next valid GO. A new GO from DONE restarts immediately (same rules as IDLE).
- result changes only on entry to DONE (or on reset). During CALC, RESULT still reads the previous value.
- done_irq = done; busy = (state==CALC).
- The multiplier is a WIDTH x NBITS product, combinational within one cycle, upper bits discarded. Discarding cannot lose information for N <= NMAX.

Test Plan:
- Reset, then read all four words -> N=0, GO=0, STATUS=0, RESULT=0; busy=0, done_irq=0.
- Write N=5, GO=1 at E0 -> busy=1 for 5 cycles; STATUS=1 after E0+5; RESULT=120 (0x78); done_irq=1.
- Write N=12, GO=1 -> done after 12 edges; RESULT=0x1C8CFC00 (479001600); err=0.
- Write N=13, GO=1 -> next cycle STATUS=3 (err=1, done=1), RESULT=0, busy never asserts. Then N=0, GO=1 -> after 1 edge STATUS=1, RESULT=1.
- N=6, GO, then at E0+2 write N=3 and GO=1 -> both ignored; RESULT=720 at E0+6; N reads 6.
- N=10, GO, assert rst asynchronously at E0+4 (between edges) -> immediately busy=0 and all registers at reset values. Then N=4, GO -> RESULT=24 after 4 edges.
